// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates the MIPS fetch and data ports onto one Avalon-MM master, round-robin on ties.
// Optional MIPS_MEM_SUBWORD_EN enables byte/half data accesses with misalignment errors.
module mips_cpu_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    // Instruction fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    // Data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    // Avalon-MM master
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        last_data_q, last_data_d;
    logic        gnt_data_q, gnt_data_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;

    logic        grant_data;
    logic        misaligned;
    logic [3:0]  d_be;
    logic [31:0] d_wd;
    logic [31:0] load_data;

`ifdef MIPS_MEM_SUBWORD_EN
    logic [1:0] off_q, off_d;
    logic [1:0] size_q, size_d;
    logic [31:0] shifted;

    always_comb begin
        misaligned = ((d_size == 2'b01) && d_addr[0]) || (d_size[1] && (d_addr[1:0] != 2'b00));
        unique case (d_size)
            2'b00: begin
                d_be = 4'b0001 << d_addr[1:0];
                d_wd = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be = 4'b0011 << d_addr[1:0];
                d_wd = {2{d_wdata[15:0]}};
            end
            default: begin
                d_be = 4'hF;
                d_wd = d_wdata;
            end
        endcase
    end

    // Little-endian lane steering: shift the addressed lane down, then zero-extend.
    always_comb begin
        shifted = rdata_q >> {off_q, 3'b000};
        unique case (size_q)
            2'b00:   load_data = {24'h0, shifted[7:0]};
            2'b01:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^i_addr[1:0];
`else
    assign misaligned = 1'b0;
    assign d_be       = 4'hF;
    assign d_wd       = d_wdata;
    assign load_data  = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{i_addr[1:0], d_addr[1:0], d_size};
`endif

    // Data wins a tie unless it was the port granted last.
    assign grant_data = d_req && (!i_req || !last_data_q);

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        gnt_data_d  = gnt_data_q;
        we_d        = we_q;
        err_d       = err_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
`ifdef MIPS_MEM_SUBWORD_EN
        off_d       = off_q;
        size_d      = size_q;
`endif
        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    last_data_d = grant_data;
                    gnt_data_d  = grant_data;
                    rdata_d     = 32'h0;
                    if (grant_data) begin
                        address_d   = {d_addr[31:2], 2'b00};
                        we_d        = d_we;
                        writedata_d = d_wd;
                        be_d        = d_be;
                        err_d       = misaligned;
`ifdef MIPS_MEM_SUBWORD_EN
                        off_d       = d_addr[1:0];
                        size_d      = d_size;
`endif
                        state_d     = misaligned ? StResp : StReq;
                    end else begin
                        address_d   = {i_addr[31:2], 2'b00};
                        we_d        = 1'b0;
                        writedata_d = 32'h0;
                        be_d        = 4'hF;
                        err_d       = 1'b0;
`ifdef MIPS_MEM_SUBWORD_EN
                        off_d       = 2'b00;
                        size_d      = 2'b10;
`endif
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (!waitrequest) begin
                    rdata_d = readdata;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_data_q <= 1'b0;
            gnt_data_q  <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            address_q   <= 32'h0;
            writedata_q <= 32'h0;
            be_q        <= 4'h0;
            rdata_q     <= 32'h0;
`ifdef MIPS_MEM_SUBWORD_EN
            off_q       <= 2'b00;
            size_q      <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            gnt_data_q  <= gnt_data_d;
            we_q        <= we_d;
            err_q       <= err_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
`ifdef MIPS_MEM_SUBWORD_EN
            off_q       <= off_d;
            size_q      <= size_d;
`endif
        end
    end

    assign busy       = (state_q != StIdle);
    assign read       = (state_q == StReq) && !we_q;
    assign write      = (state_q == StReq) && we_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = be_q;

    assign i_done  = (state_q == StResp) && !gnt_data_q;
    assign d_done  = (state_q == StResp) && gnt_data_q;
    assign d_err   = d_done && err_q;
    assign i_rdata = i_done ? rdata_q : 32'h0;
    // Stores and faulted accesses return zero.
    assign d_rdata = (d_done && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed self-checking bench for mips_cpu_mem_arbiter; subword checks run when
// MIPS_MEM_SUBWORD_EN is defined, word-only checks otherwise.
module tb_mips_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [1:0]  d_size = 2'b10;
    logic [31:0] d_wdata = 32'h0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'h0;
    logic        busy;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_cpu_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_address", address, 32'h0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_be", byteenable, 0);
        check("rst_i_done", i_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_d_err", d_err, 0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_busy", busy, 0);

        // Fetch, zero wait states, low address bits ignored
        i_req = 1'b1; i_addr = 32'hBFC00002; readdata = 32'h24020005;
        tick();
        check("fetch_read", read, 1);
        check("fetch_write", write, 0);
        check("fetch_addr", address, 32'hBFC00000);
        check("fetch_be", byteenable, 4'hF);
        check("fetch_busy", busy, 1);
        tick();
        check("fetch_i_done", i_done, 1);
        check("fetch_i_rdata", i_rdata, 32'h24020005);
        check("fetch_d_done", d_done, 0);
        check("fetch_resp_read", read, 0);
        i_req = 1'b0;
        tick();
        check("fetch_idle_done", i_done, 0);
        check("fetch_idle_rdata", i_rdata, 32'h0);
        check("fetch_idle_busy", busy, 0);

        // Two simultaneous requests: data first, then instruction
        i_req = 1'b1; i_addr = 32'h00003000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00002000; d_size = 2'b10;
        readdata = 32'h11223344;
        tick();
        check("tie1_addr", address, 32'h00002000);
        check("tie1_read", read, 1);
        check("tie1_write", write, 0);
        tick();
        check("tie1_d_done", d_done, 1);
        check("tie1_i_done", i_done, 0);
        check("tie1_d_rdata", d_rdata, 32'h11223344);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        check("tie_gap_busy", busy, 0);
        i_req = 1'b1; d_req = 1'b1;
        tick();
        check("tie2_addr", address, 32'h00003000);
        check("tie2_read", read, 1);
        check("tie2_write", write, 0);
        tick();
        check("tie2_i_done", i_done, 1);
        check("tie2_d_done", d_done, 0);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Word store with three wait states
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00001000; d_size = 2'b10;
        d_wdata = 32'hDEADBEEF; waitrequest = 1'b1; readdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) waitrequest = 1'b0;
            check("st_write", write, 1);
            check("st_read", read, 0);
            check("st_addr", address, 32'h00001000);
            check("st_wdata", writedata, 32'hDEADBEEF);
            check("st_be", byteenable, 4'hF);
            check("st_no_done", d_done, 0);
        end
        tick();
        check("st_d_done", d_done, 1);
        check("st_d_rdata", d_rdata, 32'h0);
        check("st_resp_write", write, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();

`ifdef MIPS_MEM_SUBWORD_EN
        // Byte load from the top lane
        d_req = 1'b1; d_addr = 32'h00001003; d_size = 2'b00; readdata = 32'hAB000000;
        tick();
        check("ldb_be", byteenable, 4'b1000);
        check("ldb_addr", address, 32'h00001000);
        check("ldb_read", read, 1);
        tick();
        check("ldb_done", d_done, 1);
        check("ldb_rdata", d_rdata, 32'h000000AB);
        check("ldb_err", d_err, 0);
        d_req = 1'b0;
        tick();
        // Misaligned half: no bus cycle, error response next cycle
        d_req = 1'b1; d_addr = 32'h00001001; d_size = 2'b01;
        tick();
        check("mis_done", d_done, 1);
        check("mis_err", d_err, 1);
        check("mis_rdata", d_rdata, 32'h0);
        check("mis_read", read, 0);
        d_req = 1'b0;
        tick();
        check("mis_idle_err", d_err, 0);
`else
        // Size and low address bits ignored: full word access
        d_req = 1'b1; d_addr = 32'h00001003; d_size = 2'b00; readdata = 32'hAB000000;
        tick();
        check("ldw_be", byteenable, 4'hF);
        check("ldw_addr", address, 32'h00001000);
        check("ldw_read", read, 1);
        tick();
        check("ldw_done", d_done, 1);
        check("ldw_rdata", d_rdata, 32'hAB000000);
        check("ldw_err", d_err, 0);
        d_req = 1'b0;
        tick();
`endif

        // Reset during REQ aborts; a fresh fetch then completes
        i_req = 1'b1; i_addr = 32'h00400000; waitrequest = 1'b1;
        tick();
        check("abort_read", read, 1);
        reset = 1'b1; i_req = 1'b0;
        tick();
        check("abort_read_off", read, 0);
        check("abort_busy", busy, 0);
        check("abort_i_done", i_done, 0);
        check("abort_addr", address, 32'h0);
        reset = 1'b0; waitrequest = 1'b0;
        tick();
        check("abort_no_done", i_done, 0);
        i_req = 1'b1; i_addr = 32'h00400004; readdata = 32'h8C820000;
        tick();
        check("post_read", read, 1);
        check("post_addr", address, 32'h00400004);
        tick();
        check("post_i_done", i_done, 1);
        check("post_i_rdata", i_rdata, 32'h8C820000);
        i_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
